lives_manager: RTL and testbench

//   Owns the player's life count that the heart overlay renders. Turns collision

---
 rtl/lives_manager.sv | 192 +++++++++++++++++++
 tb/tb_lives_manager.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_manager.sv
`default_nettype none
// ============================================================================
//  Module   : lives_manager
//  Purpose  : Player life bookkeeping for the HUD heart overlay. It converts
//             hazard hits and heart pickups into a saturating life count and
//             runs a post-hit invulnerability window that is timed in video
//             frames. It also raises game over and drives a blink gate so the
//             hearts flash while the player is invulnerable.
//  Ports    : clk           - system/pixel clock
//             rst_n         - asynchronous active-low reset
//             frame_tick_i  - one-cycle pulse per video frame
//             hit_i         - level, player overlaps a hazard
//             bonus_i       - level, player overlaps a heart pickup
//             restart_i     - one-cycle pulse, start a new game
//             lives_o       - current life count
//             invuln_o      - high during the invulnerability window
//             hearts_show_o - 0 blanks the hearts for this frame
//             game_over_o   - high once lives reach 0, until restart
//             life_lost_o   - one-cycle pulse per accepted hit
//  Revision : 1.0 - initial release
// ============================================================================
module lives_manager #(
  parameter int unsigned MAX_LIVES     = 2,
  parameter int unsigned INVULN_FRAMES = 90,
  parameter int unsigned BLINK_SHIFT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick_i,
  input  logic       hit_i,
  input  logic       bonus_i,
  input  logic       restart_i,
  output logic [1:0] lives_o,
  output logic       invuln_o,
  output logic       hearts_show_o,
  output logic       game_over_o,
  output logic       life_lost_o
);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_INVULN = 2'd1,
    ST_OVER   = 2'd2
  } state_e;

  localparam logic [1:0] c_MAX_LIVES     = 2'(MAX_LIVES);
  localparam logic [7:0] c_INVULN_FRAMES = 8'(INVULN_FRAMES);
  localparam int unsigned c_BLINK_BIT    = BLINK_SHIFT;

  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       bonus_q;
  logic       invuln_q, invuln_d;
  logic       hearts_show_q, hearts_show_d;
  logic       game_over_q, game_over_d;
  logic       life_lost_q, life_lost_d;

  logic       w_bonus_edge;
  logic       w_can_gain;

  // A held pickup overlap must only grant one life.
  assign w_bonus_edge = bonus_i & ~bonus_q;
  assign w_can_gain   = (lives_q < c_MAX_LIVES);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    blink_cnt_d = blink_cnt_q;
    life_lost_d = 1'b0;

    if (restart_i) begin
      state_d     = ST_PLAY;
      lives_d     = c_MAX_LIVES;
      inv_cnt_d   = 8'd0;
      blink_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          // A hit in the same cycle as a pickup edge takes precedence and
          // the pickup is dropped.
          if (hit_i) begin
            life_lost_d = 1'b1;
            if (lives_q > 2'd1) begin
              lives_d     = lives_q - 2'd1;
              inv_cnt_d   = c_INVULN_FRAMES;
              blink_cnt_d = 8'd0;
              state_d     = ST_INVULN;
            end else begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end
          end else if (w_bonus_edge && w_can_gain) begin
            lives_d = lives_q + 2'd1;
          end
        end

        ST_INVULN: begin
          if (w_bonus_edge && w_can_gain) begin
            lives_d = lives_q + 2'd1;
          end
          if (frame_tick_i) begin
            blink_cnt_d = blink_cnt_q + 8'd1;
            // The tick that sees 1 closes the window, so it spans exactly
            // INVULN_FRAMES ticks.
            if (inv_cnt_q <= 8'd1) begin
              inv_cnt_d = 8'd0;
              state_d   = ST_PLAY;
            end else begin
              inv_cnt_d = inv_cnt_q - 8'd1;
            end
          end
        end

        ST_OVER: begin
          lives_d = 2'd0;
        end

        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so they are registered yet
  // reflect the sampled event one clock later.
  always_comb begin
    invuln_d      = (state_d == ST_INVULN);
    game_over_d   = (state_d == ST_OVER);
    hearts_show_d = 1'b1;
    if (state_d == ST_INVULN) begin
      hearts_show_d = ~blink_cnt_d[c_BLINK_BIT];
    end
  end

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLAY;
      lives_q     <= c_MAX_LIVES;
      inv_cnt_q   <= 8'd0;
      blink_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Pickup edge detector history; keeps sampling even during restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bonus_q <= 1'b0;
    end else begin
      bonus_q <= bonus_i;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invuln_q      <= 1'b0;
      hearts_show_q <= 1'b1;
      game_over_q   <= 1'b0;
      life_lost_q   <= 1'b0;
    end else begin
      invuln_q      <= invuln_d;
      hearts_show_q <= hearts_show_d;
      game_over_q   <= game_over_d;
      life_lost_q   <= life_lost_d;
    end
  end

  assign lives_o       = lives_q;
  assign invuln_o      = invuln_q;
  assign hearts_show_o = hearts_show_q;
  assign game_over_o   = game_over_q;
  assign life_lost_o   = life_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_lives_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lives_manager
//  Purpose  : Self-checking bench for lives_manager with default parameters
//             (MAX_LIVES=2, INVULN_FRAMES=90, BLINK_SHIFT=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lives_manager;

  localparam int c_MAX    = 2;
  localparam int c_FRAMES = 90;
  localparam int c_SHIFT  = 3;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       hit;
  logic       bonus;
  logic       restart;
  logic [1:0] lives;
  logic       invuln;
  logic       hearts_show;
  logic       game_over;
  logic       life_lost;

  int total;
  int bad;

  // Behavioural reference: remaining window frames, blink frames elapsed.
  int m_lives;
  int m_win;
  int m_blink;
  bit m_over;
  bit m_prev_bonus;
  bit m_ll;

  lives_manager dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick_i  (frame_tick),
    .hit_i         (hit),
    .bonus_i       (bonus),
    .restart_i     (restart),
    .lives_o       (lives),
    .invuln_o      (invuln),
    .hearts_show_o (hearts_show),
    .game_over_o   (game_over),
    .life_lost_o   (life_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fr;
    logic       ht;
    logic       bn;
    logic       rs;
    logic [1:0] lv;
    logic       inv;
    logic       shw;
    logic       go;
    logic       ll;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lives      = c_MAX;
    m_win        = 0;
    m_blink      = 0;
    m_over       = 1'b0;
    m_prev_bonus = 1'b0;
    m_ll         = 1'b0;
  endtask

  task automatic model_update(input bit f, input bit h, input bit b, input bit r);
    bit gain;
    gain = b && !m_prev_bonus;
    m_prev_bonus = b;
    m_ll = 1'b0;
    if (r) begin
      m_lives = c_MAX;
      m_win   = 0;
      m_blink = 0;
      m_over  = 1'b0;
    end else if (m_over) begin
      // game over: nothing moves
    end else if (m_win == 0) begin
      if (h) begin
        m_ll = 1'b1;
        if (m_lives >= 2) begin
          m_lives = m_lives - 1;
          m_win   = c_FRAMES;
          m_blink = 0;
        end else begin
          m_lives = 0;
          m_over  = 1'b1;
        end
      end else if (gain) begin
        m_lives = (m_lives + 1 > c_MAX) ? c_MAX : m_lives + 1;
      end
    end else begin
      if (gain) m_lives = (m_lives + 1 > c_MAX) ? c_MAX : m_lives + 1;
      if (f) begin
        m_blink = (m_blink + 1) % 256;
        m_win   = m_win - 1;
      end
    end
  endtask

  task automatic step(input bit f, input bit h, input bit b, input bit r);
    frame_tick = f;
    hit        = h;
    bonus      = b;
    restart    = r;
    @(posedge clk);
    #1;
    model_update(f, h, b, r);
  endtask

  task automatic chk_model(input string tag);
    int exp_show;
    exp_show = (m_win > 0 && !m_over) ? (((m_blink >> c_SHIFT) & 1) == 0 ? 1 : 0) : 1;
    chk({tag, ".lives"},     int'(lives),       m_lives);
    chk({tag, ".invuln"},    int'(invuln),      (m_win > 0 && !m_over) ? 1 : 0);
    chk({tag, ".show"},      int'(hearts_show), exp_show);
    chk({tag, ".game_over"}, int'(game_over),   int'(m_over));
    chk({tag, ".life_lost"}, int'(life_lost),   int'(m_ll));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    hit        = 1'b0;
    bonus      = 1'b0;
    restart    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int ll_cnt;
    bit b_lvl;

    total = 0;
    bad   = 0;

    //            fr    ht    bn    rs    lives inv   show  go    ll
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // idle
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1}; // hit
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // hit ignored
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0}; // bonus edge
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0}; // held, tick
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // restart
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1}; // hit+bonus
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // idle
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // restart

    // ---------------- reset state ----------------
    do_reset();
    chk("reset.lives",     int'(lives),       2);
    chk("reset.invuln",    int'(invuln),      0);
    chk("reset.show",      int'(hearts_show), 1);
    chk("reset.game_over", int'(game_over),   0);
    chk("reset.life_lost", int'(life_lost),   0);

    // ---------------- table vectors ----------------
    foreach (vecs[i]) begin
      step(vecs[i].fr, vecs[i].ht, vecs[i].bn, vecs[i].rs);
      chk($sformatf("vec%0d.lives", i),  int'(lives),       int'(vecs[i].lv));
      chk($sformatf("vec%0d.invuln", i), int'(invuln),      int'(vecs[i].inv));
      chk($sformatf("vec%0d.show", i),   int'(hearts_show), int'(vecs[i].shw));
      chk($sformatf("vec%0d.go", i),     int'(game_over),   int'(vecs[i].go));
      chk($sformatf("vec%0d.ll", i),     int'(life_lost),   int'(vecs[i].ll));
    end

    // ---------------- long hit hold, window length and blink ----------------
    do_reset();
    ll_cnt = 0;
    for (int c = 0; c < 500; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (life_lost) ll_cnt++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold.lives",    int'(lives),  1);
    chk("hold.ll_count", ll_cnt,       1);
    chk("hold.invuln",   int'(invuln), 1);
    for (int k = 1; k <= c_FRAMES; k++) begin
      step(1'b1, (k % 7) == 0, 1'b0, 1'b0);
      if (k < c_FRAMES) begin
        chk($sformatf("win.invuln@%0d", k), int'(invuln), 1);
        chk($sformatf("win.show@%0d", k), int'(hearts_show), ((k >> 3) & 1) == 0 ? 1 : 0);
        chk($sformatf("win.lives@%0d", k), int'(lives), 1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("win.end_invuln", int'(invuln),      0);
    chk("win.end_show",   int'(hearts_show), 1);

    // ---------------- fatal hit, game over, restart ----------------
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("over.lives", int'(lives),     0);
    chk("over.go",    int'(game_over), 1);
    chk("over.ll",    int'(life_lost), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("over.stuck_lives", int'(lives),     0);
    chk("over.stuck_go",    int'(game_over), 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("restart.lives", int'(lives),     2);
    chk("restart.go",    int'(game_over), 0);
    chk("restart.inv",   int'(invuln),    0);

    // ---------------- bonus held in window ----------------
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bonus_hold.lives",  int'(lives),  2);
    chk("bonus_hold.invuln", int'(invuln), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bonus_ceiling.lives", int'(lives), 2);

    // ---------------- asynchronous reset mid-window ----------------
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_arst.invuln", int'(invuln),      1);
    chk("pre_arst.show",   int'(hearts_show), 1); // 50 ticks: bit3 of 50 is 0
    frame_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.lives",  int'(lives),       2);
    chk("arst.invuln", int'(invuln),      0);
    chk("arst.show",   int'(hearts_show), 1);
    chk("arst.go",     int'(game_over),   0);
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_arst.lives",  int'(lives),  2);
    chk("post_arst.invuln", int'(invuln), 0);

    // ---------------- randomized against reference model ----------------
    do_reset();
    b_lvl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 4) == 0) b_lvl = ~b_lvl;
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0,
           b_lvl,
           $urandom_range(0, 299) == 0);
      chk_model($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
